pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage RV32I pipeline. Computes, every cycle, the `keep` (hold) and `nop` (bubble) controls for the IF/PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also drives the PC redirect select. Hazards handled, in priority order: data-memory wait, taken branch/jump resolved in MEM, and load-use dependency. A small FSM tracks memory waits, detects memory timeouts, and keeps saturating performance counters.

## Interface
- `MEM_TIMEOUT`, default 64: number of consecutive wait cycles after which the memory access is declared failed.
- `CNT_W`, default 16: width of each performance counter.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1 each: the ID instruction actually reads that source.
- `ex_wreg` in 5: destination register of the instruction in EX (ID/EX register output).
- `ex_regwrite` in 1: the EX instruction writes a register.
- `ex_is_load` in 1: the EX instruction is a load (MemtoReg selects memory).
- `br_taken` in 1: branch/jump in MEM is taken; the target is already latched in EX/MEM.
- `dmem_req` in 1: the MEM-stage instruction is accessing data memory.
- `dmem_ack` in 1: data memory completes the access this cycle.
- `pc_sel` out 1: 1 loads the branch target into the PC; 0 loads PC+4.
- `if_keep`, `id_keep`, `ex_keep`, `mem_keep` out 1 each: hold the PC, IF/ID, ID/EX and EX/MEM registers.
- `id_nop`, `ex_nop`, `mem_nop`, `wb_nop` out 1 each: clear the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- `mem_err` out 1: sticky memory-timeout flag.
- `state` out 2: current FSM state.
- `lu_cnt`, `flush_cnt`, `memwait_cnt` out `CNT_W` each: performance counters.

## Operation
- **Hazard terms.** All are combinational from the current inputs.
  - mem_stall = `dmem_req` & !`dmem_ack`.
  - lu = `ex_is_load` & `ex_regwrite` & (`ex_wreg` != 0) & ((`id_use_rs1` & `id_rs1` == `ex_wreg`) | (`id_use_rs2` & `id_rs2` == `ex_wreg`)).
- **FSM states and transitions.**
  - RUN=0, MEM_WAIT=1, ERR=2.
  - RUN → MEM_WAIT when mem_stall.
  - MEM_WAIT → RUN when `dmem_ack`.
  - MEM_WAIT → ERR when the wait count reaches `MEM_TIMEOUT` without ack.
  - ERR is absorbing until reset.
- **Output priority.** Outputs are combinational from state and inputs. The first matching case applies; every unlisted output is 0.
  1. State ERR: all four keep signals = 1, `wb_nop` = 1, `mem_err` = 1.
  2. mem_stall (in RUN or MEM_WAIT): all four keep signals = 1, `wb_nop` = 1. `br_taken` and lu are ignored this cycle; they re-present while the pipeline is held.
  3. `br_taken`: `pc_sel` = 1, and `id_nop` = `ex_nop` = `mem_nop` = 1. This discards the three younger instructions.
  4. lu: `if_keep` = `id_keep` = 1 and `ex_nop` = 1. This inserts one bubble.
  5. Otherwise all outputs are 0 and the pipeline advances.
- **Invariant.** keep and nop are never both 1 for the same register. The EX stage gives keep priority over nop, so asserting both would hide a flush.
- **Wait counter.** The internal wait counter is `$clog2(MEM_TIMEOUT+1)` bits wide.
  - It clears in RUN.
  - It increments on each mem_stall cycle.
  - ERR is entered on the edge at which the counter would reach `MEM_TIMEOUT`.
- **Performance counters.** All saturate at all-ones and never wrap.
  - `lu_cnt` counts cycles in which case 4 applies.
  - `flush_cnt` counts cycles in which case 3 applies.
  - `memwait_cnt` counts cycles in which case 2 applies.

## Timing
- **Reset.** Asynchronous assertion and synchronous-edge release. While `rst` = 0:
  - `state` = RUN, `mem_err` = 0, and all counters = 0.
  - All keep/nop outputs and `pc_sel` are forced to 0.
- **Latency.** Hazard response has zero latency: outputs reflect the same-cycle inputs and are sampled by the pipeline registers at the next rising edge. Only the state, wait counter, `mem_err` and the performance counters are registered.
- **Load-use.** Costs exactly 1 cycle. On the following cycle `ex_is_load` = 0, because EX now holds a bubble, so lu drops.
- **Taken branch.** Costs 3 bubbles; the target PC is fetched on the cycle after `pc_sel` = 1.
- **Ack on first cycle.** An ack in the same cycle as the first `dmem_req` produces no stall and no state change.
- **Release.** An ack in MEM_WAIT releases all keeps in that same cycle, and the state returns to RUN at the next edge.
- **Simultaneous events.**
  - mem_stall with `br_taken`: the memory stall wins.
  - `br_taken` with lu: the branch wins, and the lu instruction is flushed.
- **Reset mid-operation.** Reset during MEM_WAIT or ERR returns the block to RUN with counters cleared; no pending state survives.

## Structure
- **Shared package `pipe_ctrl_pkg`.** Holds:
  - the state encodings (RUN/MEM_WAIT/ERR);
  - the hazard-priority constants;
  - the default `MEM_TIMEOUT`/`CNT_W` values.
- **Sub-module `load_use_detect`.** A purely combinational producer of lu from the ID and EX fields, reusable by a later forwarding unit.
- **Top level.** Contains the FSM, the wait counter, the priority mux and three saturating-counter instances. Factor these as one `sat_counter` helper, kept in the same file.

## Test plan
- **Load-use.** EX holds `lw x5` (`ex_is_load` = 1, `ex_wreg` = 5); ID has `id_rs2` = 5 with `id_use_rs2` = 1 → for 1 cycle `if_keep` = `id_keep` = `ex_nop` = 1; next cycle all 0; `lu_cnt` = 1. Repeat with `ex_wreg` = 0 → no stall.
- **Taken branch.** `br_taken` = 1 for 1 cycle → `pc_sel` = 1 and `id_nop` = `ex_nop` = `mem_nop` = 1; `flush_cnt` = 1. Also assert lu in the same cycle → lu is ignored and `lu_cnt` is unchanged.
- **Memory wait.** `dmem_req` = 1 with ack delayed 3 cycles → all keeps = 1 and `wb_nop` = 1 for 3 cycles, `state` = 1, then release on the ack cycle; `memwait_cnt` = 3.
- **Timeout.** `MEM_TIMEOUT` = 4 and no ack → ERR after 4 wait cycles; `mem_err` = 1 and all keeps stay 1; assert `rst` = 0 → `state` = 0, `mem_err` = 0, counters = 0.
- **Saturation.** `CNT_W` = 3 with 10 consecutive load-use cycles → `lu_cnt` holds at 7.
- **Invariant check.** Random stimulus for 10k cycles, asserting that keep and nop are never both 1 for any stage.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encodings, hazard priorities and control-word decode for the hazard controller
package pipe_ctrl_pkg;
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] ERR      = 2'd2;
    localparam int DEF_MEM_TIMEOUT = 64;
    localparam int DEF_CNT_W       = 16;
    // Ordered lowest to highest priority so a larger value always wins.
    typedef enum logic [2:0] {HZ_NONE, HZ_LU, HZ_BR, HZ_MEM, HZ_ERR} hazard_t;
    typedef struct packed {
        logic pc_sel;
        logic if_keep;
        logic id_keep;
        logic ex_keep;
        logic mem_keep;
        logic id_nop;
        logic ex_nop;
        logic mem_nop;
        logic wb_nop;
    } ctrl_t;
    function automatic ctrl_t hazard_ctrl(input hazard_t h);
        return ctrl_t'(h >= HZ_MEM ? 9'b0_1111_0001 :
                       h == HZ_BR  ? 9'b1_0000_1110 :
                       h == HZ_LU  ? 9'b0_1100_0100 : 9'b0);
    endfunction
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load still in EX
module load_use_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic [4:0] ex_wreg,
    input  logic       ex_regwrite,
    input  logic       ex_is_load,
    output logic       lu
);
    assign lu = ex_is_load & ex_regwrite & (ex_wreg != 5'd0) &
                ((id_use_rs1 & (id_rs1 == ex_wreg)) | (id_use_rs2 & (id_rs2 == ex_wreg)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller with memory-wait FSM, timeout and saturating perf counters
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_wreg,
    input  logic             ex_regwrite,
    input  logic             ex_is_load,
    input  logic             br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_sel,
    output logic             if_keep,
    output logic             id_keep,
    output logic             ex_keep,
    output logic             mem_keep,
    output logic             id_nop,
    output logic             ex_nop,
    output logic             mem_nop,
    output logic             wb_nop,
    output logic             mem_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    logic          lu;
    logic          mem_stall;
    hazard_t       hz;
    ctrl_t         ctl;
    logic [1:0]    state_nxt;
    logic [WW-1:0] wcnt;
    logic [WW-1:0] wcnt_inc;
    load_use_detect u_lud (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_wreg    (ex_wreg),
        .ex_regwrite(ex_regwrite),
        .ex_is_load (ex_is_load),
        .lu         (lu)
    );
    assign mem_stall = dmem_req & ~dmem_ack;
    assign hz = state == ERR ? HZ_ERR :
                mem_stall    ? HZ_MEM :
                br_taken     ? HZ_BR  :
                lu           ? HZ_LU  : HZ_NONE;
    // Pipeline controls are held inactive while reset is asserted.
    assign ctl = rst ? hazard_ctrl(hz) : ctrl_t'(9'b0);
    assign {pc_sel, if_keep, id_keep, ex_keep, mem_keep, id_nop, ex_nop, mem_nop, wb_nop} = ctl;
    assign mem_err = state == ERR;
    assign wcnt_inc = wcnt + 1'b1;
    assign state_nxt = state == ERR ? ERR :
                       mem_stall    ? (wcnt_inc == WW'(MEM_TIMEOUT) ? ERR : MEM_WAIT) : RUN;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= state_nxt == MEM_WAIT ? wcnt_inc : '0;
        end
    sat_counter #(.W(CNT_W)) u_lu_cnt (.clk(clk), .rst(rst), .inc(hz == HZ_LU), .cnt(lu_cnt));
    sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(hz == HZ_BR), .cnt(flush_cnt));
    sat_counter #(.W(CNT_W)) u_memwait_cnt (.clk(clk), .rst(rst), .inc(hz == HZ_MEM), .cnt(memwait_cnt));
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table plus hand sequences for stalls, timeout, reset and saturation
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_wreg;
    logic       id_use_rs1, id_use_rs2, ex_regwrite, ex_is_load, br_taken, dmem_req, dmem_ack;
    logic       pc_sel, if_keep, id_keep, ex_keep, mem_keep, id_nop, ex_nop, mem_nop, wb_nop, mem_err;
    logic [1:0] state;
    logic [2:0] lu_cnt, flush_cnt, memwait_cnt;
    logic [8:0] outs;
    int checks = 0;
    int errors = 0;

    localparam logic [8:0] O_NONE  = 9'h000;
    localparam logic [8:0] O_LU    = 9'h0C4;
    localparam logic [8:0] O_BR    = 9'h10E;
    localparam logic [8:0] O_STALL = 9'h0F1;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_wreg(ex_wreg), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
        .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_sel(pc_sel), .if_keep(if_keep), .id_keep(id_keep), .ex_keep(ex_keep), .mem_keep(mem_keep),
        .id_nop(id_nop), .ex_nop(ex_nop), .mem_nop(mem_nop), .wb_nop(wb_nop),
        .mem_err(mem_err), .state(state),
        .lu_cnt(lu_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
    );

    always #5 clk = ~clk;
    assign outs = {pc_sel, if_keep, id_keep, ex_keep, mem_keep, id_nop, ex_nop, mem_nop, wb_nop};

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] wreg;
        logic       rw, ld, br, req, ack;
        logic [8:0] exp;
    } vec_t;
    vec_t tv[15];

    function automatic vec_t mk(input string n, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] wreg,
                                input logic rw, input logic ld, input logic br,
                                input logic req, input logic ack, input logic [8:0] exp);
        vec_t v;
        v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.wreg = wreg;
        v.rw = rw; v.ld = ld; v.br = br; v.req = req; v.ack = ack; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
        ex_wreg = v.wreg; ex_regwrite = v.rw; ex_is_load = v.ld;
        br_taken = v.br; dmem_req = v.req; dmem_ack = v.ack;
    endtask

    task automatic idle();
        apply(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE));
    endtask

    task automatic set_lu();
        id_rs2 = 5'd5; id_use_rs2 = 1'b1; ex_wreg = 5'd5; ex_regwrite = 1'b1; ex_is_load = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b0; idle();
        @(negedge clk); rst = 1'b1;
    endtask

    initial begin
        tv[0]  = mk("idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE);
        tv[1]  = mk("lu_rs2",        0, 5, 0, 1, 5, 1, 1, 0, 0, 0, O_LU);
        tv[2]  = mk("lu_x0",         0, 0, 0, 1, 0, 1, 1, 0, 0, 0, O_NONE);
        tv[3]  = mk("lu_rs1",        7, 0, 1, 0, 7, 1, 1, 0, 0, 0, O_LU);
        tv[4]  = mk("rs1_unused",    7, 3, 0, 1, 7, 1, 1, 0, 0, 0, O_NONE);
        tv[5]  = mk("no_regwrite",   7, 0, 1, 0, 7, 0, 1, 0, 0, 0, O_NONE);
        tv[6]  = mk("not_load",      7, 0, 1, 0, 7, 1, 0, 0, 0, 0, O_NONE);
        tv[7]  = mk("br",            0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR);
        tv[8]  = mk("br_over_lu",    0, 5, 0, 1, 5, 1, 1, 1, 0, 0, O_BR);
        tv[9]  = mk("req_ack",       0, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_NONE);
        tv[10] = mk("br_req_ack",    0, 0, 0, 0, 0, 0, 0, 1, 1, 1, O_BR);
        tv[11] = mk("stall_over_br", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_STALL);
        tv[12] = mk("release_lu",    0, 5, 0, 1, 5, 1, 1, 0, 1, 1, O_LU);
        tv[13] = mk("stall",         0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_STALL);
        tv[14] = mk("after_stall",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE);

        rst = 1'b0; idle(); br_taken = 1'b1; dmem_req = 1'b1;
        #12;
        chk("rst_outs", outs, O_NONE);
        chk("rst_state", state, 0);
        chk("rst_mem_err", mem_err, 0);
        chk("rst_cnts", {lu_cnt, flush_cnt, memwait_cnt}, 0);
        @(negedge clk); rst = 1'b1; idle();

        foreach (tv[i]) begin
            @(negedge clk); apply(tv[i]); #2;
            chk(tv[i].name, outs, tv[i].exp);
        end
        do_reset();

        // single-cycle load-use bubble
        @(negedge clk); set_lu(); #2;
        chk("lu_cycle", outs, O_LU);
        @(negedge clk); ex_is_load = 1'b0; #2;
        chk("lu_next", outs, O_NONE);
        chk("lu_cnt1", lu_cnt, 1);

        // branch beats a simultaneous load-use
        @(negedge clk); set_lu(); br_taken = 1'b1; #2;
        chk("br_flush", outs, O_BR);
        @(negedge clk); idle(); #2;
        chk("flush_cnt1", flush_cnt, 1);
        chk("lu_cnt_kept", lu_cnt, 1);

        // three wait cycles then ack
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); dmem_req = 1'b1; dmem_ack = 1'b0; #2;
            chk("wait_outs", outs, O_STALL);
            chk("wait_state", state, i == 0 ? 0 : 1);
        end
        @(negedge clk); dmem_ack = 1'b1; #2;
        chk("ack_release", outs, O_NONE);
        chk("ack_state", state, 1);
        @(negedge clk); idle(); #2;
        chk("back_run", state, 0);
        chk("memwait_cnt3", memwait_cnt, 3);
        @(negedge clk); dmem_req = 1'b1; dmem_ack = 1'b1; #2;
        chk("first_ack", outs, O_NONE);
        @(negedge clk); idle(); #2;
        chk("first_ack_state", state, 0);
        chk("first_ack_cnt", memwait_cnt, 3);

        // timeout after four waits
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); dmem_req = 1'b1; dmem_ack = 1'b0; #2;
            chk("to_wait", outs, O_STALL);
        end
        @(negedge clk); idle(); #2;
        chk("err_state", state, 2);
        chk("err_flag", mem_err, 1);
        chk("err_outs", outs, O_STALL);
        chk("memwait_sat", memwait_cnt, 7);
        @(negedge clk); br_taken = 1'b1; dmem_req = 1'b1; dmem_ack = 1'b1; #2;
        chk("err_absorb", outs, O_STALL);
        #1 rst = 1'b0; #1;
        chk("async_state", state, 0);
        chk("async_err", mem_err, 0);
        chk("async_cnts", {lu_cnt, flush_cnt, memwait_cnt}, 0);
        chk("async_outs", outs, O_NONE);
        @(negedge clk); rst = 1'b1; idle();

        // ten load-use cycles saturate a 3-bit counter
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); set_lu();
        end
        @(negedge clk); idle(); #2;
        chk("lu_sat", lu_cnt, 7);

        // keep and nop never both set for one register
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            rst = $urandom_range(0, 63) != 0;
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_wreg = 5'($urandom_range(0, 3));
            id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
            ex_regwrite = 1'($urandom); ex_is_load = 1'($urandom);
            br_taken = $urandom_range(0, 3) == 0;
            dmem_req = $urandom_range(0, 3) == 0; dmem_ack = 1'($urandom);
            #2;
            chk("invariant", {id_keep & id_nop, ex_keep & ex_nop, mem_keep & mem_nop}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
